// File: rtl/linear_proj_pkg.sv
// ============================================================================
// Module  : linear_proj_pkg
// Brief   : Shared matmul geometry constants and serializer state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package linear_proj_pkg;

    localparam int WIDTH_OUT   = 8;
    localparam int CHUNK_SIZE  = 2;
    localparam int NUM_CORES_A = 2;
    localparam int NUM_CORES_B = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/out_word_mux.sv
// ============================================================================
// Module  : out_word_mux
// Brief   : Combinational word selector; index i picks bits [i*WORD_W +: WORD_W].
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module out_word_mux #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_WORDS*WORD_W-1:0] i_din,
    input  logic [IDX_W-1:0]            i_idx,
    output logic [WORD_W-1:0]           o_word
);

    // Compare-based select keeps out-of-range indices at zero for non-power-of-2 counts.
    always_comb begin
        o_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_word = i_din[i*WORD_W +: WORD_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/matmul_out_serializer.sv
// ============================================================================
// Module  : matmul_out_serializer
// Brief   : Captures a matmul result bundle and drains it word by word into
//           an output BRAM port. Optional macro MATSER_STALL_CNT_EN adds a
//           saturating stall_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_out_serializer
    import linear_proj_pkg::*;
#(
    parameter  int TOTAL_INPUT_W = 2,
    parameter  int TOTAL_MODULES = 4,
    parameter  int NUM_BLOCKS    = 4,
    localparam int WORD_W        = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A,
    localparam int SLICES        = NUM_CORES_B * TOTAL_MODULES,
    localparam int WORDS         = TOTAL_INPUT_W * SLICES,
    localparam int LANE_W        = WORD_W * SLICES,
    localparam int ADDR_W        = (NUM_BLOCKS * WORDS > 1) ? $clog2(NUM_BLOCKS * WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_module,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data [TOTAL_INPUT_W],
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              done
`ifdef MATSER_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int FLAT_W = TOTAL_INPUT_W * LANE_W;

    ser_state_t         r_state;
    logic               r_rdy;
    logic               r_m_valid;
    logic               r_done;
    logic [WORD_W-1:0]  r_m_data;
    logic [ADDR_W-1:0]  r_addr;
    logic [IDX_W-1:0]   r_idx;
    logic [BLK_W-1:0]   r_blk;
    logic [FLAT_W-1:0]  r_hold;

    logic [FLAT_W-1:0]  w_in_flat;
    logic [FLAT_W-1:0]  w_mux_src;
    logic [IDX_W-1:0]   w_mux_idx;
    logic [WORD_W-1:0]  w_next_word;
    logic               w_out_hs;
    logic               w_in_hs;
    logic               w_in_ready;
    logic               w_last_word;
    logic               w_last_blk;

    // Lane 0 occupies the LSBs, so word index = lane*SLICES + slice maps linearly.
    generate
        for (genvar l = 0; l < TOTAL_INPUT_W; l++) begin : g_flat
            assign w_in_flat[l*LANE_W +: LANE_W] = in_data[l];
        end
    endgenerate

    assign w_out_hs    = r_m_valid && m_ready;
    assign w_last_word = (r_idx == IDX_W'(WORDS - 1));
    assign w_last_blk  = (r_blk == BLK_W'(NUM_BLOCKS - 1));
    assign w_in_ready  = en_module && ((r_state == IDLE) ? r_rdy : (w_out_hs && w_last_word));
    assign w_in_hs     = in_valid && w_in_ready;

    // A fresh capture presents word 0 of the incoming bundle straight away.
    assign w_mux_src = w_in_hs ? w_in_flat : r_hold;
    assign w_mux_idx = w_in_hs ? '0 : r_idx + IDX_W'(1);

    out_word_mux #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (WORDS),
        .IDX_W     (IDX_W)
    ) u_word_mux (
        .i_din  (w_mux_src),
        .i_idx  (w_mux_idx),
        .o_word (w_next_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rdy     <= 1'b0;
            r_m_valid <= 1'b0;
            r_done    <= 1'b0;
            r_m_data  <= '0;
            r_addr    <= '0;
            r_idx     <= '0;
            r_blk     <= '0;
            r_hold    <= '0;
        end else if (!en_module) begin
            r_state   <= IDLE;
            r_rdy     <= 1'b0;
            r_m_valid <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_idx     <= '0;
            r_blk     <= '0;
        end else begin
            r_done <= w_out_hs && w_last_word && w_last_blk;
            if (w_out_hs) begin
                r_addr <= (w_last_word && w_last_blk) ? '0 : r_addr + ADDR_W'(1);
            end
            if (w_out_hs && w_last_word) begin
                r_blk <= w_last_blk ? '0 : r_blk + BLK_W'(1);
            end
            if (w_in_hs) begin
                r_hold    <= w_in_flat;
                r_m_data  <= w_next_word;
                r_idx     <= '0;
                r_m_valid <= 1'b1;
                r_state   <= DRAIN;
                r_rdy     <= 1'b0;
            end else if (w_out_hs) begin
                if (w_last_word) begin
                    r_state   <= IDLE;
                    r_m_valid <= 1'b0;
                    r_rdy     <= 1'b1;
                end else begin
                    r_idx    <= r_idx + IDX_W'(1);
                    r_m_data <= w_next_word;
                end
            end else if (r_state == IDLE) begin
                r_rdy <= 1'b1;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_addr   = r_addr;
    assign done     = r_done;

`ifdef MATSER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!en_module) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !m_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/matmul_out_serializer.md
MATMUL_OUT_SERIALIZER -- requirements
Module: matmul_out_serializer

Interface
REQ-001 SHALL have parameter TOTAL_INPUT_W, default 2: number of input lanes per capture.
REQ-002 SHALL have parameter TOTAL_MODULES, default 4: number of matmul modules concatenated per lane.
REQ-003 SHALL have parameter NUM_BLOCKS, default 4: number of captures per output matrix.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port en_module, input, 1 bit: block enable.
REQ-007 SHALL have port in_valid, input, 1 bit: result bundle valid (driven by the matmul wrapper out_valid).
REQ-008 SHALL have port in_ready, output, 1 bit: bundle may be captured.
REQ-009 SHALL have port in_data, input, TOTAL_INPUT_W x LANE_W unpacked array: result lanes; LANE_W = WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES.
REQ-010 SHALL have port m_valid, output, 1 bit: output word valid.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts word.
REQ-012 SHALL have port m_data, output, WORD_W bits: output word; WORD_W = WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A.
REQ-013 SHALL have port m_addr, output, ADDR_W bits: output-BRAM word address; ADDR_W = clog2(NUM_BLOCKS*WORDS).
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the matrix is fully drained.

Function
REQ-015 SHALL define SLICES = NUM_CORES_B*TOTAL_MODULES and WORDS = TOTAL_INPUT_W*SLICES words per capture.
REQ-016 SHALL use states IDLE (empty, in_ready=1) and DRAIN (holding a capture, m_valid=1).
REQ-017 SHALL capture all lanes into a holding register on in_valid && in_ready and enter DRAIN the next cycle, with zero bubble cycles.
REQ-018 SHALL emit words in order lane 0 slice 0 (LSBs) through lane 0 slice SLICES-1, then lane 1 onward.
REQ-019 SHALL hold m_data and m_addr stable while m_valid && !m_ready.
REQ-020 SHALL advance the word index and m_addr by one on each m_valid && m_ready.
REQ-021 SHALL assert in_ready during the final-word handshake of a capture so a new bundle captures in the same cycle (back-to-back, no idle cycle); otherwise return to IDLE.
REQ-022 SHALL ignore in_valid while in_ready=0; upstream holds its data.
REQ-023 SHALL wrap m_addr to 0 after address NUM_BLOCKS*WORDS-1 and pulse done on the cycle after that handshake.
REQ-024 SHALL, when en_module=0, synchronously force IDLE, clear counters and address, drop m_valid, and deassert in_ready.
REQ-025 SHALL perform no arithmetic on data; slicing only.

Reset
REQ-026 SHALL on rst_n=0 asynchronously set state IDLE and clear in_ready, m_valid, m_addr, word counter, block counter, done and m_data to 0; an in-flight capture is discarded.
REQ-027 SHALL assert in_ready only from the first clock edge after rst_n release when en_module=1.

Configuration
REQ-028 SHALL, with MATSER_STALL_CNT_EN defined, add output stall_cnt (32 bits) counting cycles where m_valid && !m_ready, saturating, cleared by reset and en_module=0.
REQ-029 SHALL, without MATSER_STALL_CNT_EN, omit the stall_cnt port and its logic entirely.

Structure
REQ-030 SHALL take WIDTH_OUT, CHUNK_SIZE, NUM_CORES_A and NUM_CORES_B from linear_proj_pkg; SHALL add a state enum type ser_state_t to that package.
REQ-031 SHALL keep the word-select multiplexer in one sub-module, out_word_mux (combinational, index -> WORD_W slice).

Verification
REQ-032 SHALL verify reset: assert rst_n=0 mid-DRAIN -> m_valid=0, m_addr=0, in_ready=0 immediately; in_ready=1 one cycle after release.
REQ-033 SHALL verify ordering: one capture with m_ready=1 constantly (defaults: 8 words) -> 8 consecutive words in REQ-018 order, addresses 0..7.
REQ-034 SHALL verify backpressure: toggle m_ready 1/0 every cycle -> each word held stable while stalled, no loss or duplication, stall_cnt=7 when the macro is enabled.
REQ-035 SHALL verify back-to-back: in_valid held high for 4 captures -> 32 words with no gap, in_ready high only on each 8th handshake, done pulses once after address 31, m_addr returns to 0.
REQ-036 SHALL verify enable drop: en_module=0 at word 3 -> m_valid=0 next cycle; on re-enable, the next capture starts at address 0.
